// File: rtl/core_hazard_unit.sv
// Purpose: hazard/forwarding controller for the Selen 5-stage core: stage enables/kills, PC stop, bubble insert, redirect, operand forwarding.
// Latency: all outputs combinational from inputs + registered FSM state; FSM/counters update on rising clk.
// Backpressure: stall_wb freezes every stage and the FSM; load-use and stall_dec hold IF/DEC and bubble DEC/EXE.
// Optional: define CORE_HAZ_PERF_EN to build the saturating 32-bit stall-cycle counter on haz_stall_cnt_out.
module core_hazard_unit #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] haz_dec_rs1_in,
  input  logic [AW-1:0] haz_dec_rs2_in,
  input  logic [AW-1:0] haz_exe_rs1_in,
  input  logic [AW-1:0] haz_exe_rs2_in,
  input  logic [AW-1:0] haz_exe_rd_in,
  input  logic          haz_exe_we_in,
  input  logic          haz_mem_we_in,
  input  logic          haz_wb_we_in,
  input  logic [AW-1:0] haz_mem_rd_in,
  input  logic [AW-1:0] haz_wb_rd_in,
  input  logic [1:0]    haz_exe_cmd_in,
  input  logic          haz_brnch_tknn_in,
  input  logic          haz_stall_dec_in,
  input  logic          haz_stall_wb_in,
  output logic [3:0]    haz_enb_bus_out,
  output logic [3:0]    haz_kill_bus_out,
  output logic          haz_pc_stop_out,
  output logic          haz_nop_gen_out,
  output logic          haz_mux_trn_out,
  output logic [1:0]    haz_fwd_rs1_out,
  output logic [1:0]    haz_fwd_rs2_out,
  output logic [31:0]   haz_stall_cnt_out
);

  typedef enum logic {
    RUN      = 1'b0,
    LD_STALL = 1'b1
  } state_t;

  localparam logic [1:0] CMD_JUMP   = 2'b01;
  localparam logic [1:0] CMD_BRANCH = 2'b10;
  localparam logic [1:0] CMD_LOAD   = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // The hazard cycle itself is bubble 1, so LD_STALL covers LOAD_LAT-1 more
  // cycles; counting down to 0 inclusive means preloading LOAD_LAT-2.
  localparam logic [CW-1:0] CNT_INIT = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          load_use;
  logic          redirect;

  logic [3:0]    enb;
  logic [3:0]    kill;
  logic          pc_stop;
  logic          nop_gen;
  logic          mux_trn;
  logic [1:0]    fwd_rs1;
  logic [1:0]    fwd_rs2;

  // MEM is the younger producer, so it wins over WB; x0 is hardwired zero.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                         input logic          mem_we,
                                         input logic [AW-1:0] mem_rd,
                                         input logic          wb_we,
                                         input logic [AW-1:0] wb_rd);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (mem_we && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_we && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // Hazard detection terms.
  assign load_use = (haz_exe_cmd_in == CMD_LOAD) && haz_exe_we_in &&
                    (haz_exe_rd_in != '0) &&
                    ((haz_exe_rd_in == haz_dec_rs1_in) || (haz_exe_rd_in == haz_dec_rs2_in));

  assign redirect = (haz_exe_cmd_in == CMD_JUMP) ||
                    ((haz_exe_cmd_in == CMD_BRANCH) && haz_brnch_tknn_in);

  // Operand forwarding selects, independent of stall priority.
  always_comb begin
    fwd_rs1 = fwd_sel(haz_exe_rs1_in, haz_mem_we_in, haz_mem_rd_in, haz_wb_we_in, haz_wb_rd_in);
    fwd_rs2 = fwd_sel(haz_exe_rs2_in, haz_mem_we_in, haz_mem_rd_in, haz_wb_we_in, haz_wb_rd_in);
  end

  // Prioritised pipeline control and FSM next-state.
  always_comb begin
    enb       = 4'b1111;
    kill      = 4'b0000;
    pc_stop   = 1'b0;
    nop_gen   = 1'b0;
    mux_trn   = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;

    if (haz_stall_wb_in) begin
      // Whole pipe frozen; FSM holds so the bubble count survives the stall.
      enb     = 4'b0000;
      pc_stop = 1'b1;
    end else if (redirect) begin
      // Younger instructions in IF/DEC are on the wrong path.  Any pending
      // load bubbles belonged to the killed DEC instruction, so drop them.
      mux_trn   = 1'b1;
      kill      = 4'b0011;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (state == LD_STALL) begin
      enb[0]  = 1'b0;
      pc_stop = 1'b1;
      nop_gen = 1'b1;
      if (cnt == '0) begin
        state_nxt = RUN;
      end else begin
        cnt_nxt = cnt - CW'(1);
      end
    end else if (load_use) begin
      enb[0]  = 1'b0;
      pc_stop = 1'b1;
      nop_gen = 1'b1;
      if (LOAD_LAT > 1) begin
        state_nxt = LD_STALL;
        cnt_nxt   = CNT_INIT;
      end
    end else if (haz_stall_dec_in) begin
      enb[0]  = 1'b0;
      pc_stop = 1'b1;
      nop_gen = 1'b1;
    end
  end

  // FSM state and bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are forced to a safe, fully-killed pattern while reset is held.
  always_comb begin
    if (rst) begin
      haz_enb_bus_out  = 4'b0000;
      haz_kill_bus_out = 4'b1111;
      haz_pc_stop_out  = 1'b1;
      haz_nop_gen_out  = 1'b0;
      haz_mux_trn_out  = 1'b0;
      haz_fwd_rs1_out  = FWD_RF;
      haz_fwd_rs2_out  = FWD_RF;
    end else begin
      haz_enb_bus_out  = enb;
      haz_kill_bus_out = kill;
      haz_pc_stop_out  = pc_stop;
      haz_nop_gen_out  = nop_gen;
      haz_mux_trn_out  = mux_trn;
      haz_fwd_rs1_out  = fwd_rs1;
      haz_fwd_rs2_out  = fwd_rs2;
    end
  end

`ifdef CORE_HAZ_PERF_EN
  logic [31:0] stall_cnt;

  // Count every non-reset cycle in which the PC is held, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (pc_stop && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign haz_stall_cnt_out = stall_cnt;
`else
  assign haz_stall_cnt_out = 32'd0;
`endif

endmodule
